// File: rtl/pia_irq_sequencer_if.sv
// PIA interrupt sequencer bus interface.
// CPU control register, strobes and C1/C2 control lines.
interface pia_irq_sequencer_if;
    logic       cr_we;
    logic [5:0] cr_wdata;
    logic [7:0] cr_rdata;
    logic       port_read;
    logic       deselect;
    logic       c1_in;
    logic       c2_in;
    logic       c2_out;
    logic       c2_oe;
    logic       irq_n;

    modport master (
        output cr_we,
        output cr_wdata,
        input  cr_rdata,
        output port_read,
        output deselect,
        output c1_in,
        output c2_in,
        input  c2_out,
        input  c2_oe,
        input  irq_n
    );

    modport slave (
        input  cr_we,
        input  cr_wdata,
        output cr_rdata,
        input  port_read,
        input  deselect,
        input  c1_in,
        input  c2_in,
        output c2_out,
        output c2_oe,
        output irq_n
    );
endinterface

// File: rtl/pia_irq_sequencer.sv
// PIA-style C1/C2 interrupt flags, clear lock and C2 output sequencer.
// Define PIA_IRQ_SYNC_EN to add a two-flop input synchronizer on C1/C2.
module pia_irq_sequencer (
    input  logic                 clk,
    input  logic                 reset,
    pia_irq_sequencer_if.slave   bus
);

    typedef enum logic {
        C2_HIGH = 1'b0,
        C2_LOW  = 1'b1
    } c2_state_t;

    logic [5:0] ctrl_q, ctrl_d;
    logic       irq1_q, irq1_d;
    logic       irq2_q, irq2_d;
    logic       lock_q, lock_d;
    logic       c1_prev_q;
    logic       c2_prev_q;
    logic       c1_s;
    logic       c2_s;
    logic       c1_act;
    logic       c2_act;
    logic       clr;
    logic       mode_hs;
    logic       mode_pulse;
    logic       mode_manual;
    c2_state_t  c2_state_q, c2_state_d;

`ifdef PIA_IRQ_SYNC_EN
    logic [1:0] c1_sync_q;
    logic [1:0] c2_sync_q;

    // Two-flop synchronizer; reset preloads the live input level.
    always_ff @(posedge clk) begin
        if (reset) begin
            c1_sync_q <= {2{bus.c1_in}};
            c2_sync_q <= {2{bus.c2_in}};
        end else begin
            c1_sync_q <= {c1_sync_q[0], bus.c1_in};
            c2_sync_q <= {c2_sync_q[0], bus.c2_in};
        end
    end

    assign c1_s = c1_sync_q[1];
    assign c2_s = c2_sync_q[1];
`else
    assign c1_s = bus.c1_in;
    assign c2_s = bus.c2_in;
`endif

    // Previous-sample registers; reset loads the live input so no edge follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            c1_prev_q <= bus.c1_in;
            c2_prev_q <= bus.c2_in;
        end else begin
            c1_prev_q <= c1_s;
            c2_prev_q <= c2_s;
        end
    end

    assign c1_act = ctrl_q[1] ? (c1_s & ~c1_prev_q)
                              : (~c1_s & c1_prev_q);
    assign c2_act = ctrl_q[4] ? (c2_s & ~c2_prev_q)
                              : (~c2_s & c2_prev_q);

    assign mode_hs     = (ctrl_q[5:3] == 3'b100);
    assign mode_pulse  = (ctrl_q[5:3] == 3'b101);
    assign mode_manual = (ctrl_q[5:4] == 2'b11);

    // A read and a deselect together only move the lock, never clear flags.
    assign clr = lock_q & bus.deselect & ~bus.port_read;

    // Next state for control, flags and the pending-clear lock.
    always_comb begin
        ctrl_d = ctrl_q;
        irq1_d = irq1_q;
        irq2_d = irq2_q;
        lock_d = lock_q;

        if (bus.cr_we) begin
            ctrl_d = bus.cr_wdata;
        end

        if (c1_act) begin
            irq1_d = 1'b1;
        end else if (clr) begin
            irq1_d = 1'b0;
        end

        if (ctrl_q[5]) begin
            irq2_d = 1'b0;
        end else if (c2_act) begin
            irq2_d = 1'b1;
        end else if (clr) begin
            irq2_d = 1'b0;
        end

        if (bus.port_read) begin
            lock_d = 1'b1;
        end else if (bus.deselect) begin
            lock_d = 1'b0;
        end
    end

    // C2 output sequencer next state for handshake and pulse modes.
    always_comb begin
        c2_state_d = c2_state_q;
        unique case (1'b1)
            mode_hs: begin
                if (c1_act) begin
                    c2_state_d = C2_HIGH;
                end else if (bus.port_read) begin
                    c2_state_d = C2_LOW;
                end
            end
            mode_pulse: begin
                if (bus.port_read) begin
                    c2_state_d = C2_LOW;
                end else if (bus.deselect) begin
                    c2_state_d = C2_HIGH;
                end
            end
            default: begin
                c2_state_d = c2_state_q;
            end
        endcase
    end

    // State registers; reset wins over every strobe and pending action.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= 6'd0;
            irq1_q     <= 1'b0;
            irq2_q     <= 1'b0;
            lock_q     <= 1'b0;
            c2_state_q <= C2_HIGH;
        end else begin
            ctrl_q     <= ctrl_d;
            irq1_q     <= irq1_d;
            irq2_q     <= irq2_d;
            lock_q     <= lock_d;
            c2_state_q <= c2_state_d;
        end
    end

    assign bus.cr_rdata = {irq1_q, irq2_q, ctrl_q};
    assign bus.c2_oe    = ctrl_q[5];
    assign bus.c2_out   = mode_manual ? ctrl_q[3]
                                      : (c2_state_q == C2_HIGH);
    assign bus.irq_n    = ~((irq1_q & ctrl_q[0]) |
                            (irq2_q & ctrl_q[3] & ~ctrl_q[5]));

endmodule

// File: tb/tb_pia_irq_sequencer.sv
// Randomized bench for pia_irq_sequencer with a cycle-level reference model.
// Honours PIA_IRQ_SYNC_EN for the extra input latency.
module tb_pia_irq_sequencer;

    logic clk;
    logic reset;

    pia_irq_sequencer_if bus();

    pia_irq_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIA_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    int n_chk;
    int n_err;

    bit [5:0] m_ctrl;
    bit       m_f1, m_f2, m_lock, m_c2hi;
    bit [1:0] m_h1, m_h2;
    bit       m_p1, m_p2;
    bit       c1v, c2v;

    task automatic check(input string tag,
                         input logic [7:0] got,
                         input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic bit m_c2out();
        if (m_ctrl[5:4] == 2'b11) return m_ctrl[3];
        return m_c2hi;
    endfunction

    function automatic bit m_irqn();
        return !((m_f1 && m_ctrl[0]) ||
                 (m_f2 && m_ctrl[3] && !m_ctrl[5]));
    endfunction

    task automatic step(input bit rst, input bit we,
                        input bit [5:0] wd, input bit pr,
                        input bit ds, input bit c1, input bit c2);
        bit s1, s2, e1, e2, clr;
        @(negedge clk);
        reset         = rst;
        bus.cr_we     = we;
        bus.cr_wdata  = wd;
        bus.port_read = pr;
        bus.deselect  = ds;
        bus.c1_in     = c1;
        bus.c2_in     = c2;
        if (rst) begin
            m_ctrl = 0; m_f1 = 0; m_f2 = 0;
            m_lock = 0; m_c2hi = 1;
            m_h1 = {c1, c1}; m_h2 = {c2, c2};
            m_p1 = c1; m_p2 = c2;
        end else begin
`ifdef PIA_IRQ_SYNC_EN
            s1 = m_h1[1]; s2 = m_h2[1];
`else
            s1 = c1; s2 = c2;
`endif
            e1 = m_ctrl[1] ? (s1 && !m_p1) : (!s1 && m_p1);
            e2 = m_ctrl[4] ? (s2 && !m_p2) : (!s2 && m_p2);
            clr = m_lock && ds && !pr;
            if (e1) m_f1 = 1;
            else if (clr) m_f1 = 0;
            if (m_ctrl[5]) m_f2 = 0;
            else if (e2) m_f2 = 1;
            else if (clr) m_f2 = 0;
            if (m_ctrl[5:3] == 3'b100) begin
                if (e1) m_c2hi = 1;
                else if (pr) m_c2hi = 0;
            end else if (m_ctrl[5:3] == 3'b101) begin
                if (pr) m_c2hi = 0;
                else if (ds) m_c2hi = 1;
            end
            if (pr) m_lock = 1;
            else if (ds) m_lock = 0;
            if (we) m_ctrl = wd;
            m_h1 = {m_h1[0], c1}; m_h2 = {m_h2[0], c2};
            m_p1 = s1; m_p2 = s2;
        end
        @(posedge clk);
        #1;
        check("rdata", bus.cr_rdata, {m_f1, m_f2, m_ctrl});
        check("c2_out", {7'd0, bus.c2_out}, {7'd0, m_c2out()});
        check("c2_oe", {7'd0, bus.c2_oe}, {7'd0, m_ctrl[5]});
        check("irq_n", {7'd0, bus.irq_n}, {7'd0, m_irqn()});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 6'd0, 0, 0, c1v, c2v);
    endtask

    int low_cnt;

    initial begin
        n_chk = 0;
        n_err = 0;
        c1v = 0;
        c2v = 0;
        reset = 1;
        bus.cr_we = 0; bus.cr_wdata = 0;
        bus.port_read = 0; bus.deselect = 0;
        bus.c1_in = 0; bus.c2_in = 0;

        step(1, 0, 6'd0, 0, 0, 0, 0);
        step(1, 0, 6'd0, 0, 0, 0, 0);
        check("rst_rdata", bus.cr_rdata, 8'h00);
        check("rst_c2out", {7'd0, bus.c2_out}, 8'h01);
        check("rst_c2oe", {7'd0, bus.c2_oe}, 8'h00);
        check("rst_irqn", {7'd0, bus.irq_n}, 8'h01);

        step(0, 1, 6'b000011, 0, 0, 0, 0);
        c1v = 1;
        step(0, 0, 6'd0, 0, 0, c1v, c2v);
        idle(LAT - 1);
        check("c1_rise_rdata", bus.cr_rdata, 8'h83);
        check("c1_rise_irqn", {7'd0, bus.irq_n}, 8'h00);

        step(0, 0, 6'd0, 1, 0, c1v, c2v);
        idle(2);
        check("lock_hold", bus.cr_rdata, 8'h83);
        step(0, 0, 6'd0, 0, 1, c1v, c2v);
        check("lock_clr", bus.cr_rdata, 8'h03);
        check("lock_clr_irqn", {7'd0, bus.irq_n}, 8'h01);

        c1v = 0; idle(3);
        c1v = 1; idle(3);
        step(0, 0, 6'd0, 0, 1, c1v, c2v);
        check("ds_nolock", bus.cr_rdata, 8'h83);
        step(0, 0, 6'd0, 1, 0, c1v, c2v);
        c1v = 0; idle(3);
        c1v = 1;
        idle(LAT - 1);
        step(0, 0, 6'd0, 0, 1, c1v, c2v);
        check("set_wins", bus.cr_rdata, 8'h83);
        step(0, 0, 6'd0, 0, 1, c1v, c2v);
        check("ds_after_rel", bus.cr_rdata, 8'h83);

        step(0, 1, 6'b100100, 0, 0, c1v, c2v);
        check("hs_oe", {7'd0, bus.c2_oe}, 8'h01);
        step(0, 0, 6'd0, 1, 0, c1v, c2v);
        check("hs_low", {7'd0, bus.c2_out}, 8'h00);
        c1v = 0;
        step(0, 0, 6'd0, 0, 0, c1v, c2v);
        idle(LAT - 1);
        check("hs_high", {7'd0, bus.c2_out}, 8'h01);

        step(0, 1, 6'b101100, 0, 0, c1v, c2v);
        low_cnt = 0;
        step(0, 0, 6'd0, 1, 0, c1v, c2v);
        if (!bus.c2_out) low_cnt++;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            if (!bus.c2_out) low_cnt++;
        end
        step(0, 0, 6'd0, 0, 1, c1v, c2v);
        if (!bus.c2_out) low_cnt++;
        check("pulse_len", low_cnt[7:0], 8'd4);
        check("pulse_end", {7'd0, bus.c2_out}, 8'h01);

        step(0, 1, 6'b100100, 0, 0, c1v, c2v);
        step(0, 0, 6'd0, 1, 0, c1v, c2v);
        check("mid_hs_low", {7'd0, bus.c2_out}, 8'h00);
        step(1, 0, 6'd0, 0, 0, c1v, c2v);
        check("mrst_c2out", {7'd0, bus.c2_out}, 8'h01);
        check("mrst_c2oe", {7'd0, bus.c2_oe}, 8'h00);
        check("mrst_rdata", bus.cr_rdata, 8'h00);
        check("mrst_irqn", {7'd0, bus.irq_n}, 8'h01);
        idle(LAT + 1);
        check("mrst_noedge", bus.cr_rdata, 8'h00);
        step(0, 0, 6'd0, 0, 1, c1v, c2v);
        check("mrst_nolock", bus.cr_rdata, 8'h00);

        for (int i = 0; i < 2000; i++) begin
            bit rr, we, pr, ds;
            bit [5:0] wd;
            rr = ($urandom_range(0, 99) == 0);
            we = ($urandom_range(0, 7) == 0);
            wd = 6'($urandom());
            pr = ($urandom_range(0, 5) == 0);
            ds = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) c1v = ~c1v;
            if ($urandom_range(0, 2) == 0) c2v = ~c2v;
            step(rr, we, wd, pr, ds, c1v, c2v);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pia_irq_sequencer.md
PIA_IRQ_SEQUENCER -- requirements
Module: pia_irq_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port cr_we, input, 1 bit: write strobe for the control register.
REQ-004 SHALL have port cr_wdata, input, 6 bits: control bits b5..b0.
REQ-005 SHALL have port cr_rdata, output, 8 bits: {irq1_flag, irq2_flag, ctrl[5:0]}.
REQ-006 SHALL have port port_read, input, 1 bit: one-cycle strobe, CPU read of the peripheral data register.
REQ-007 SHALL have port deselect, input, 1 bit: chip-deselect strobe that completes a bus access.
REQ-008 SHALL have port c1_in, input, 1 bit: control line 1, input only.
REQ-009 SHALL have port c2_in, input, 1 bit: control line 2, input sample.
REQ-010 SHALL have port c2_out, output, 1 bit: control line 2 drive value.
REQ-011 SHALL have port c2_oe, output, 1 bit: control line 2 output enable.
REQ-012 SHALL have port irq_n, output, 1 bit: active-low interrupt request.

Function
REQ-013 SHALL assign ctrl bits as follows: b0 = C1 IRQ enable; b1 = C1 active edge (0 falling, 1 rising); b2 = DDR-select, stored only; b5..b3 = C2 mode.
REQ-014 SHALL load ctrl from cr_wdata on the clock where cr_we=1, taking effect the next cycle; flags are not writable.
REQ-015 SHALL detect edges by comparing the current input sample with a registered previous sample, updated every cycle; a change of b1 or b4 alone SHALL NOT create an edge.
REQ-016 SHALL set irq1_flag on the clock following an active C1 edge, regardless of b0.
REQ-017 SHALL, when b5=0, treat C2 as an input: c2_oe=0, b4 selects the edge (0 falling, 1 rising), an active edge sets irq2_flag one clock later, and b3 enables the IRQ.
REQ-018 SHALL, when b5=1, hold irq2_flag at 0 and set c2_oe=1.
REQ-019 SHALL, in handshake mode (b5..b3=100), drive c2_out low on the clock after port_read and high on the clock after an active C1 edge; if both occur in the same cycle, c2_out goes high.
REQ-020 SHALL, in pulse mode (b5..b3=101), drive c2_out low on the clock after port_read and high on the first clock with deselect=1 after that.
REQ-021 SHALL, in manual mode (b5..b4=11), drive c2_out = b3.
REQ-022 SHALL clear flags using a pending-clear lock: port_read sets the lock, and the next clock with deselect=1 clears both flags and releases the lock.
REQ-023 SHALL let a flag set event win over a clear in the same cycle, so the flag stays 1.
REQ-024 SHALL NOT clear flags on deselect when the lock is not set.
REQ-025 SHALL set or clear the lock when port_read and deselect occur in the same cycle, but SHALL NOT clear flags in that cycle.
REQ-026 SHALL drive irq_n = ~((irq1_flag & b0) | (irq2_flag & b3 & ~b5)), combinational from registered state.
REQ-027 SHALL assert irq_n immediately when an enable bit is written while its flag is already 1, that is, in the cycle after the cr_we cycle.

Reset
REQ-028 SHALL, on reset=1 at a clock edge, clear ctrl, both flags and the lock to 0.
REQ-029 SHALL, on that reset, set c2_out=1, c2_oe=0 and irq_n=1.
REQ-030 SHALL load the previous-sample registers with the current inputs during reset, so no edge is reported on the first cycle after reset.
REQ-031 SHALL let reset override all other inputs, including mid-handshake and lock-pending states, and clear any pending pulse.

Configuration
REQ-032 SHALL, with PIA_IRQ_SYNC_EN defined, pass c1_in and c2_in through a two-flop synchronizer before edge detection, adding 2 clocks to every input-to-flag latency.
REQ-033 SHALL reset both synchronizer stages to the current input value.
REQ-034 SHALL, without PIA_IRQ_SYNC_EN, sample the inputs directly, giving 1-clock edge-to-flag latency.

Verification
REQ-035 SHALL be verified as follows: write ctrl=000011, drive c1_in 0->1 -> irq1_flag=1 and irq_n=0 one clock later (three clocks with PIA_IRQ_SYNC_EN); cr_rdata=8'h83.
REQ-036 SHALL be verified as follows: with irq1_flag=1, pulse port_read, wait 2 clocks, then pulse deselect -> flag still 1 before deselect, cleared to 0 the clock after deselect, irq_n=1.
REQ-037 SHALL be verified as follows: pulse deselect with no prior port_read -> flags unchanged; then a C1 edge in the same cycle as a lock-releasing deselect -> irq1_flag stays 1.
REQ-038 SHALL be verified as follows: ctrl=100100 (handshake), pulse port_read -> c2_out=0; next active C1 falling edge -> c2_out=1.
REQ-039 SHALL be verified as follows: ctrl=101100 (pulse), pulse port_read, pulse deselect 3 clocks later -> c2_out low for exactly 4 clocks.
REQ-040 SHALL be verified as follows: assert reset mid-handshake with the lock pending -> next cycle c2_out=1, c2_oe=0, cr_rdata=8'h00, irq_n=1; an unchanged input produces no edge.
